// File: rtl/maddu_sequencer.sv
// Iterative MADDU execute sequencer: unsigned shift-add multiply accumulated into HI/LO.
// Owns the architectural HI/LO pair and stalls the front of the pipeline while busy.
module maddu_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_ACC
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic accept;
    logic last_step;

    assign accept    = (state_q == S_IDLE) && start && !flush;
    assign last_step = (cnt_q == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    // A flush aborts only during MUL; once in ACC the instruction is past the squash point.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_MUL;
            S_MUL: begin
                if (flush)          state_d = S_IDLE;
                else if (last_step) state_d = S_ACC;
            end
            S_ACC:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every value driven here gets a hold default first so no latch is inferred.
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mcand_d  = {{WIDTH{1'b0}}, rs_val};
                    mplier_d = rt_val;
                    prod_d   = '0;
                    cnt_d    = '0;
                end else if (!start) begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_MUL: begin
                if (mplier_q[0]) prod_d = prod_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
            end
            S_ACC: begin
                {hi_d, lo_d} = {hi_q, lo_q} + prod_q;
                done_d       = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        stall = accept || (state_q != S_IDLE);
        busy  = (state_q != S_IDLE);
        done  = done_q;
        hi    = hi_q;
        lo    = lo_q;
    end

endmodule

// File: doc/maddu_sequencer.md
Name: maddu_sequencer

Overview:
Multi-cycle sequencer for the MADDU (opcode 28) execute resource in the pipelined MIPS CPU. It accepts a MADDU issued from ID/EX and runs an iterative 32x32 unsigned shift-add multiply. It accumulates the 64-bit product into the architectural HI/LO pair and holds the pipeline stall line high until the result is committed. It also owns the HI/LO registers and services direct HI/LO writes (mthi/mtlo) while idle.

Parameters:
WIDTH, 32, operand width and width of each of HI/LO
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  MADDU present in EX, qualified by decoder (op==28)
flush  in  1  pipeline flush request (branch/jump squash)
rs_val  in  WIDTH  multiplicand (forwarded rs value)
rt_val  in  WIDTH  multiplier (forwarded rt value)
hi_we  in  1  write wdata into HI (mthi)
lo_we  in  1  write wdata into LO (mtlo)
wdata  in  WIDTH  data for hi_we/lo_we
stall  out  1  freeze PC, IF/ID, ID/EX while MADDU in progress
busy  out  1  sequencer not in IDLE
done  out  1  one-cycle pulse: accumulate committed
hi  out  WIDTH  architectural HI
lo  out  WIDTH  architectural LO

Behaviour:
- Reset (rst=1 at edge): state=IDLE, counter=0, internal product/multiplicand/multiplier regs=0, hi=0, lo=0, done=0. Reset overrides every in-flight operation and pending write.
- States: IDLE, MUL, ACC.
- IDLE:
  - start=1 and flush=0: latch multiplicand = zero-extended rs_val (2*WIDTH bits), multiplier = rt_val, product = 0, counter = 0; next state MUL.
  - start=1 and flush=1: start is ignored; stay IDLE.
- MUL, one step per cycle:
  - if multiplier[0], product += multiplicand (2*WIDTH-bit add, unsigned).
  - multiplicand <<= 1, multiplier >>= 1, counter++.
  - After the step with counter==WIDTH-1 (exactly WIDTH cycles in MUL), next state ACC.
- ACC: {hi,lo} <= {hi,lo} + product, modulo 2**(2*WIDTH); carry out of HI is discarded. Next state IDLE. done=1 in the following cycle (registered pulse, exactly one cycle).
- stall (combinational) = (state==IDLE & start & ~flush) | (state==MUL) | (state==ACC).
- busy (registered view) = state != IDLE.
- Latency: start cycle T (IDLE), MUL for T+1..T+WIDTH, ACC at T+WIDTH+1. New hi/lo and done=1 are visible at T+WIDTH+2. stall is high for exactly WIDTH+2 cycles (T..T+WIDTH+1).
- Back-to-back: start=1 in the done cycle is accepted; operands are latched and the operation uses the just-committed hi/lo.
- flush:
  - In MUL: abort; next state IDLE, hi/lo unchanged, no done pulse.
  - In ACC: ignored; the commit completes, because the instruction has already passed the squash point.
- hi_we/lo_we: honoured only when state==IDLE and start==0; otherwise dropped silently. Both asserted together writes wdata to both HI and LO.
- Operand inputs are sampled only in the start cycle; later changes on rs_val/rt_val have no effect.
- done is never asserted in the same cycle as stall originating from the same operation.

Test Plan:
- Reset: hold rst 2 cycles with start=1 -> hi=0, lo=0, busy=0, done=0, stall=0 after release.
- hi=lo=0, start with rs=0xFFFFFFFF, rt=0xFFFFFFFF -> stall high 34 cycles. At T+34: hi=0xFFFFFFFE, lo=0x00000001, done=1 for one cycle.
- Back-to-back: in the done cycle, start with rs=2, rt=3 -> after 34 more cycles hi=0xFFFFFFFE, lo=0x00000007.
- Wrap: mthi/mtlo set hi=lo=0xFFFFFFFF, then maddu 1*1 -> hi=0x00000000, lo=0x00000000, carry dropped.
- Flush: start rs=5, rt=7 with hi=lo=0; flush at T+10 -> state IDLE at T+11, stall low, hi=lo=0, no done. Flush in the ACC cycle -> lo=35 committed, done pulses.
- Write blocking: lo_we=1, wdata=0x1234 while busy, and again with start=1 in IDLE -> LO unchanged. The same write in idle with start=0 -> lo=0x1234 next cycle.
